// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU control path.
// Holds the opcode encodings, the micro-step encoding (T0..T4), the bit
// positions of the active-high internal control word, and a helper that
// gives the last active micro-step of each opcode.
package cpu_pkg;

  localparam int unsigned OpWidth = 4;

  localparam logic [OpWidth-1:0] OP_NOP = 4'h0;
  localparam logic [OpWidth-1:0] OP_LDA = 4'h1;
  localparam logic [OpWidth-1:0] OP_ADD = 4'h2;
  localparam logic [OpWidth-1:0] OP_SUB = 4'h3;
  localparam logic [OpWidth-1:0] OP_STA = 4'h4;
  localparam logic [OpWidth-1:0] OP_LDI = 4'h5;
  localparam logic [OpWidth-1:0] OP_JMP = 4'h6;
  localparam logic [OpWidth-1:0] OP_JC  = 4'h7;
  localparam logic [OpWidth-1:0] OP_JZ  = 4'h8;
  localparam logic [OpWidth-1:0] OP_OUT = 4'hE;
  localparam logic [OpWidth-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // Control word bits, active-high internally; inverted at the ports for _n strobes.
  localparam int unsigned CW_PC_OUT   = 0;
  localparam int unsigned CW_PC_INC   = 1;
  localparam int unsigned CW_PC_JUMP  = 2;
  localparam int unsigned CW_MAR_IN   = 3;
  localparam int unsigned CW_RAM_OUT  = 4;
  localparam int unsigned CW_RAM_IN   = 5;
  localparam int unsigned CW_IR_IN    = 6;
  localparam int unsigned CW_IR_OUT   = 7;
  localparam int unsigned CW_A_IN     = 8;
  localparam int unsigned CW_A_OUT    = 9;
  localparam int unsigned CW_B_IN     = 10;
  localparam int unsigned CW_ALU_OUT  = 11;
  localparam int unsigned CW_ALU_SUB  = 12;
  localparam int unsigned CW_FLAGS_IN = 13;
  localparam int unsigned CW_OUT_IN   = 14;
  localparam int unsigned CwWidth     = 15;

  // Last micro-step that does useful work; the counter returns to T0 after it.
  function automatic step_e last_step(input logic [OpWidth-1:0] op);
    case (op)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
      OP_LDA, OP_STA:                               last_step = T3;
      OP_ADD, OP_SUB:                               last_step = T4;
      default:                                      last_step = T1;
    endcase
  endfunction

endpackage

// File: rtl/cu_flags_reg.sv
// Two-bit ALU flag capture register {carry, zero}.
// Ports: i_clk (rising edge), i_reset (async, active-high, clears to 00),
// i_load (capture enable), i_d (flag inputs), o_q (stored flags).
module cu_flags_reg (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] flags_q;
  logic [1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (i_load) flags_d = i_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) flags_q <= 2'b00;
    else         flags_q <= flags_d;
  end

  assign o_q = flags_q;

endmodule

// File: rtl/control_unit.sv
// Microcoded sequencer for the 8-bit bus CPU.
// Steps a T0..T4 micro-counter on the falling clock edge and decodes
// (step, opcode, stored flags, halt) into the control word that steers the
// bus. ADD/SUB capture the ALU carry/zero flags on the rising edge; JC/JZ use
// them. HLT sets a latch that freezes the counter until i_reset.
// Ports: i_clk, i_reset (async, active-high), i_opcode (IR[7:4]),
// i_flag_c/i_flag_z (ALU flags), active-low bus strobes o_*_n, o_pc_inc,
// o_alu_sub, o_halt, o_step (debug view of the micro-step).
module control_unit
  import cpu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [OpWidth-1:0] i_opcode,
  input  logic               i_flag_c,
  input  logic               i_flag_z,
  output logic               o_pc_out_n,
  output logic               o_pc_inc,
  output logic               o_pc_jump_n,
  output logic               o_mar_in_n,
  output logic               o_ram_out_n,
  output logic               o_ram_in_n,
  output logic               o_ir_in_n,
  output logic               o_ir_out_n,
  output logic               o_a_in_n,
  output logic               o_a_out_n,
  output logic               o_b_in_n,
  output logic               o_alu_out_n,
  output logic               o_alu_sub,
  output logic               o_flags_in_n,
  output logic               o_out_in_n,
  output logic               o_halt,
  output logic [2:0]         o_step
);

  step_e               step_q, step_d;
  logic                halt_q, halt_d;
  logic [1:0]          flags_q;  // {carry, zero}
  logic [CwWidth-1:0]  cw;
  logic [CwWidth-1:0]  cw_act;
  logic                halt_req;

  // Control word decode.
  always_comb begin
    cw       = '0;
    halt_req = 1'b0;
    unique case (step_q)
      T0: begin
        cw[CW_PC_OUT] = 1'b1;
        cw[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_IN]   = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_IN]   = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_JUMP] = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OUT]  = flags_q[1];
            cw[CW_PC_JUMP] = flags_q[1];
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = flags_q[0];
            cw[CW_PC_JUMP] = flags_q[0];
          end
          OP_OUT: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_OUT_IN] = 1'b1;
          end
          OP_HLT:  halt_req = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        case (i_opcode)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_IN]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_IN]    = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_RAM_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          cw[CW_ALU_OUT]  = 1'b1;
          cw[CW_A_IN]     = 1'b1;
          cw[CW_FLAGS_IN] = 1'b1;
          cw[CW_ALU_SUB]  = (i_opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Next step: hold while halted, return to T0 after the last active step.
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    if (!halt_q) begin
      if (halt_req) begin
        halt_d = 1'b1;
      end else if (step_q >= last_step(i_opcode) || step_q >= T4) begin
        step_d = T0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // Reset is combinational here so a strobe dies the instant reset rises.
  assign cw_act = (i_reset || halt_q) ? '0 : cw;

  cu_flags_reg u_flags (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (cw_act[CW_FLAGS_IN]),
    .i_d     ({i_flag_c, i_flag_z}),
    .o_q     (flags_q)
  );

  assign o_pc_out_n   = ~cw_act[CW_PC_OUT];
  assign o_pc_inc     =  cw_act[CW_PC_INC];
  assign o_pc_jump_n  = ~cw_act[CW_PC_JUMP];
  assign o_mar_in_n   = ~cw_act[CW_MAR_IN];
  assign o_ram_out_n  = ~cw_act[CW_RAM_OUT];
  assign o_ram_in_n   = ~cw_act[CW_RAM_IN];
  assign o_ir_in_n    = ~cw_act[CW_IR_IN];
  assign o_ir_out_n   = ~cw_act[CW_IR_OUT];
  assign o_a_in_n     = ~cw_act[CW_A_IN];
  assign o_a_out_n    = ~cw_act[CW_A_OUT];
  assign o_b_in_n     = ~cw_act[CW_B_IN];
  assign o_alu_out_n  = ~cw_act[CW_ALU_OUT];
  assign o_alu_sub    =  cw_act[CW_ALU_SUB];
  assign o_flags_in_n = ~cw_act[CW_FLAGS_IN];
  assign o_out_in_n   = ~cw_act[CW_OUT_IN];
  assign o_halt       = halt_q;
  assign o_step       = step_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [3:0] i_opcode = 4'h0;
  logic       i_flag_c = 1'b0;
  logic       i_flag_z = 1'b0;
  logic pc_out_n, pc_inc, pc_jump_n, mar_in_n, ram_out_n, ram_in_n, ir_in_n, ir_out_n;
  logic a_in_n, a_out_n, b_in_n, alu_out_n, alu_sub, flags_in_n, out_in_n, halt;
  logic [2:0] step;

  control_unit dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_opcode     (i_opcode),
    .i_flag_c     (i_flag_c),
    .i_flag_z     (i_flag_z),
    .o_pc_out_n   (pc_out_n),
    .o_pc_inc     (pc_inc),
    .o_pc_jump_n  (pc_jump_n),
    .o_mar_in_n   (mar_in_n),
    .o_ram_out_n  (ram_out_n),
    .o_ram_in_n   (ram_in_n),
    .o_ir_in_n    (ir_in_n),
    .o_ir_out_n   (ir_out_n),
    .o_a_in_n     (a_in_n),
    .o_a_out_n    (a_out_n),
    .o_b_in_n     (b_in_n),
    .o_alu_out_n  (alu_out_n),
    .o_alu_sub    (alu_sub),
    .o_flags_in_n (flags_in_n),
    .o_out_in_n   (out_in_n),
    .o_halt       (halt),
    .o_step       (step)
  );

  always #5 i_clk = ~i_clk;

  // Active-high strobe masks in the bench's own packing of the outputs.
  localparam logic [14:0] M_PC_OUT   = 15'd1;
  localparam logic [14:0] M_PC_INC   = 15'd2;
  localparam logic [14:0] M_PC_JUMP  = 15'd4;
  localparam logic [14:0] M_MAR_IN   = 15'd8;
  localparam logic [14:0] M_RAM_OUT  = 15'd16;
  localparam logic [14:0] M_RAM_IN   = 15'd32;
  localparam logic [14:0] M_IR_IN    = 15'd64;
  localparam logic [14:0] M_IR_OUT   = 15'd128;
  localparam logic [14:0] M_A_IN     = 15'd256;
  localparam logic [14:0] M_A_OUT    = 15'd512;
  localparam logic [14:0] M_B_IN     = 15'd1024;
  localparam logic [14:0] M_ALU_OUT  = 15'd2048;
  localparam logic [14:0] M_ALU_SUB  = 15'd4096;
  localparam logic [14:0] M_FLAGS_IN = 15'd8192;
  localparam logic [14:0] M_OUT_IN   = 15'd16384;

  int total = 0;
  int bad = 0;
  logic mfc = 1'b0;  // model carry flag
  logic mfz = 1'b0;  // model zero flag
  logic [14:0] obs_w [5];
  logic [2:0]  obs_s [5];
  logic        obs_h [5];

  function automatic logic [14:0] obs();
    obs = {~out_in_n, ~flags_in_n, alu_sub, ~alu_out_n, ~b_in_n, ~a_out_n, ~a_in_n, ~ir_out_n,
           ~ir_in_n, ~ram_in_n, ~ram_out_n, ~mar_in_n, ~pc_jump_n, pc_inc, ~pc_out_n};
  endfunction

  // Falling edges from the start of fetch to the next instruction's T0.
  function automatic int lat(input logic [3:0] op);
    case (op)
      4'h1, 4'h4:                      lat = 4;
      4'h2, 4'h3:                      lat = 5;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: lat = 3;
      default:                         lat = 2;
    endcase
  endfunction

  // Reference microprogram: strobes expected in micro-step k of opcode op.
  function automatic logic [14:0] exp_word(input logic [3:0] op, input int k,
                                           input logic fc, input logic fz);
    logic [14:0] w;
    w = '0;
    if (k == 0) w = M_PC_OUT | M_MAR_IN;
    else if (k == 1) w = M_RAM_OUT | M_IR_IN | M_PC_INC;
    else begin
      case (op)
        4'h1: w = (k == 2) ? (M_IR_OUT | M_MAR_IN) : (M_RAM_OUT | M_A_IN);
        4'h2, 4'h3: begin
          if (k == 2) w = M_IR_OUT | M_MAR_IN;
          else if (k == 3) w = M_RAM_OUT | M_B_IN;
          else w = M_ALU_OUT | M_A_IN | M_FLAGS_IN | ((op == 4'h3) ? M_ALU_SUB : 15'd0);
        end
        4'h4: w = (k == 2) ? (M_IR_OUT | M_MAR_IN) : (M_A_OUT | M_RAM_IN);
        4'h5: w = M_IR_OUT | M_A_IN;
        4'h6: w = M_IR_OUT | M_PC_JUMP;
        4'h7: w = fc ? (M_IR_OUT | M_PC_JUMP) : 15'd0;
        4'h8: w = fz ? (M_IR_OUT | M_PC_JUMP) : 15'd0;
        4'hE: w = M_A_OUT | M_OUT_IN;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  // Drive one instruction for its spec latency; called at negedge+1, returns at negedge+1.
  task automatic run_op(input logic [3:0] op, input logic c, input logic z, input bit junk_t0);
    for (int k = 0; k < lat(op); k++) begin
      i_opcode = (k == 0 && junk_t0) ? 4'($urandom_range(0, 14)) : op;
      i_flag_c = c;
      i_flag_z = z;
      #3;
      obs_w[k] = obs();
      obs_s[k] = step;
      obs_h[k] = halt;
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [14:0] ew;
    #1;
    total++;
    if (obs() !== 15'd0 || step !== 3'd0 || halt !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: word=%h step=%0d halt=%b want 0/0/0", obs(), step, halt);
    end
    @(negedge i_clk);
    #1;
    i_reset = 1'b0;
    mfc = 1'b0;
    mfz = 1'b0;
    run_op(4'h2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ew = exp_word(4'h2, k, mfc, mfz);
      total++;
      if (obs_s[k] !== 3'(k) || obs_w[k] !== ew) begin
        bad++;
        $display("FAIL reset_pre_add step %0d: word=%h step=%0d want %h/%0d", k, obs_w[k],
                 obs_s[k], ew, k);
      end
    end
    // Second ADD, reset asserted in the middle of T3.
    i_opcode = 4'h2;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1;
    end
    total++;
    if (step !== 3'd3 || obs() !== (M_RAM_OUT | M_B_IN)) begin
      bad++;
      $display("FAIL reset_mid_t3_pre: word=%h step=%0d want %h/3", obs(), step,
               M_RAM_OUT | M_B_IN);
    end
    i_reset = 1'b1;
    #1;
    total++;
    if (obs() !== 15'd0 || step !== 3'd0 || halt !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_t3: word=%h step=%0d halt=%b want 0/0/0", obs(), step, halt);
    end
    @(negedge i_clk);
    #1;
    i_reset = 1'b0;
    mfc = 1'b0;
    mfz = 1'b0;
    #1;
    total++;
    if (obs() !== (M_PC_OUT | M_MAR_IN) || step !== 3'd0) begin
      bad++;
      $display("FAIL reset_release_t0: word=%h step=%0d want %h/0", obs(), step,
               M_PC_OUT | M_MAR_IN);
    end
    @(negedge i_clk);  // T0 -> T1; ride out the fetch as a NOP
    #1;
    i_opcode = 4'h0;
    @(negedge i_clk);
    #1;
    total++;
    if (step !== 3'd0) begin
      bad++;
      $display("FAIL reset_nop_return: step=%0d want 0", step);
    end
  endtask

  task automatic test_add();
    logic [3:0] prog [4] = '{4'h2, 4'h7, 4'h8, 4'h0};
    logic [14:0] ew;
    for (int i = 0; i < 4; i++) begin
      run_op(prog[i], 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < lat(prog[i]); k++) begin
        ew = exp_word(prog[i], k, mfc, mfz);
        total++;
        if (obs_s[k] !== 3'(k) || obs_w[k] !== ew || obs_h[k] !== 1'b0) begin
          bad++;
          $display("FAIL add op %h step %0d: word=%h step=%0d halt=%b want %h/%0d/0", prog[i], k,
                   obs_w[k], obs_s[k], obs_h[k], ew, k);
        end
        if ((ew & M_FLAGS_IN) != 15'd0) begin mfc = 1'b1; mfz = 1'b0; end
      end
    end
  endtask

  task automatic test_sub_jz_jc();
    logic [3:0] prog [4] = '{4'h3, 4'h8, 4'h7, 4'h0};
    logic [14:0] ew;
    for (int i = 0; i < 4; i++) begin
      run_op(prog[i], 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < lat(prog[i]); k++) begin
        ew = exp_word(prog[i], k, mfc, mfz);
        total++;
        if (obs_s[k] !== 3'(k) || obs_w[k] !== ew || obs_h[k] !== 1'b0) begin
          bad++;
          $display("FAIL sub_jz_jc op %h step %0d: word=%h step=%0d want %h/%0d", prog[i], k,
                   obs_w[k], obs_s[k], ew, k);
        end
        if ((ew & M_FLAGS_IN) != 15'd0) begin mfc = 1'b0; mfz = 1'b1; end
      end
    end
  endtask

  task automatic test_ldi_out();
    logic [3:0] prog [3] = '{4'h5, 4'hE, 4'h0};
    logic [14:0] ew;
    for (int i = 0; i < 3; i++) begin
      run_op(prog[i], 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < lat(prog[i]); k++) begin
        ew = exp_word(prog[i], k, mfc, mfz);
        total++;
        if (obs_s[k] !== 3'(k) || obs_w[k] !== ew) begin
          bad++;
          $display("FAIL ldi_out op %h step %0d: word=%h step=%0d want %h/%0d", prog[i], k,
                   obs_w[k], obs_s[k], ew, k);
        end
      end
    end
  endtask

  task automatic test_nop_unknown();
    // Flags hold c=0,z=1 here; drive the opposite so a stray capture would show.
    logic [3:0] prog [4] = '{4'hB, 4'h7, 4'h8, 4'h0};
    logic [14:0] ew;
    for (int i = 0; i < 4; i++) begin
      run_op(prog[i], 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < lat(prog[i]); k++) begin
        ew = exp_word(prog[i], k, mfc, mfz);
        total++;
        if (obs_s[k] !== 3'(k) || obs_w[k] !== ew) begin
          bad++;
          $display("FAIL nop_unknown op %h step %0d: word=%h step=%0d want %h/%0d", prog[i], k,
                   obs_w[k], obs_s[k], ew, k);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic c, z;
    logic [14:0] ew;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      c = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      run_op(op, c, z, 1'b1);
      for (int k = 0; k < lat(op); k++) begin
        ew = exp_word(op, k, mfc, mfz);
        total++;
        if (obs_s[k] !== 3'(k) || obs_w[k] !== ew || obs_h[k] !== 1'b0) begin
          bad++;
          $display("FAIL random #%0d op %h step %0d: word=%h step=%0d want %h/%0d", i, op, k,
                   obs_w[k], obs_s[k], ew, k);
        end
        if ((ew & M_FLAGS_IN) != 15'd0) begin mfc = c; mfz = z; end
      end
    end
  endtask

  task automatic test_halt();
    logic [3:0] prog [2] = '{4'h2, 4'hF};
    logic [3:0] post [3] = '{4'h7, 4'h8, 4'h0};
    logic [14:0] ew;
    for (int i = 0; i < 2; i++) begin
      run_op(prog[i], 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < lat(prog[i]); k++) begin
        ew = exp_word(prog[i], k, mfc, mfz);
        total++;
        if (obs_s[k] !== 3'(k) || obs_w[k] !== ew || obs_h[k] !== 1'b0) begin
          bad++;
          $display("FAIL halt_pre op %h step %0d: word=%h step=%0d want %h/%0d", prog[i], k,
                   obs_w[k], obs_s[k], ew, k);
        end
        if ((ew & M_FLAGS_IN) != 15'd0) begin mfc = 1'b1; mfz = 1'b1; end
      end
    end
    for (int n = 0; n < 20; n++) begin
      i_opcode = 4'($urandom);
      i_flag_c = 1'($urandom_range(0, 1));
      i_flag_z = 1'($urandom_range(0, 1));
      #3;
      total++;
      if (halt !== 1'b1 || obs() !== 15'd0 || step !== 3'd2) begin
        bad++;
        $display("FAIL halt_frozen cycle %0d: halt=%b word=%h step=%0d want 1/0/2", n, halt,
                 obs(), step);
      end
      @(negedge i_clk);
      #1;
    end
    i_reset = 1'b1;
    #1;
    total++;
    if (halt !== 1'b0 || obs() !== 15'd0 || step !== 3'd0) begin
      bad++;
      $display("FAIL halt_reset: halt=%b word=%h step=%0d want 0/0/0", halt, obs(), step);
    end
    @(negedge i_clk);
    #1;
    i_reset = 1'b0;
    mfc = 1'b0;
    mfz = 1'b0;
    // Flags were 11 before reset; JC/JZ must now be idle.
    for (int i = 0; i < 3; i++) begin
      run_op(post[i], 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < lat(post[i]); k++) begin
        ew = exp_word(post[i], k, mfc, mfz);
        total++;
        if (obs_s[k] !== 3'(k) || obs_w[k] !== ew || obs_h[k] !== 1'b0) begin
          bad++;
          $display("FAIL halt_resume op %h step %0d: word=%h step=%0d halt=%b want %h/%0d/0",
                   post[i], k, obs_w[k], obs_s[k], obs_h[k], ew, k);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge i_clk);
    test_reset();
    test_add();
    test_sub_jz_jc();
    test_ldi_out();
    test_nop_unknown();
    test_random();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
